// File: rtl/vram_pkg.sv
// Shared definitions for the framebuffer port arbiter: default window base,
// grant-state encoding and write-FIFO entry sizing.
package vram_pkg;

    localparam logic [31:0] ADDR_BASE_DEF = 32'h0000_8000;
    localparam int          VRAM_AW_DEF   = 15;

    typedef enum logic [1:0] {
        G_IDLE     = 2'd0,
        G_SCAN     = 2'd1,
        G_WRITE    = 2'd2,
        G_FORCE_WR = 2'd3
    } grant_e;

    // A queued store is {word address, data}
    function automatic int entry_width(input int aw);
        return aw + 32;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write FIFO holding core stores until the RAM port is free.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module vram_wr_fifo #(
    parameter int W     = 47,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop against occupancy
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Entry storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the single-port framebuffer RAM between buffered core stores and the
// scanout reader; scanout wins unless queued writes have waited too long.
module vram_port_arbiter
    import vram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = ADDR_BASE_DEF,
    parameter int          VRAM_AW    = VRAM_AW_DEF,
    parameter int          FIFO_DEPTH = 4,
    parameter int          STARVE_LIM = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               video_we,
    input  logic [31:0]        video_addr,
    input  logic [31:0]        video_data,
    output logic               core_busy,
    input  logic               scan_req,
    input  logic [VRAM_AW-1:0] scan_addr,
    output logic               scan_gnt,
    output logic               scan_valid,
    output logic [31:0]        scan_data,
    output logic               vram_en,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [31:0]        vram_wdata,
    input  logic [31:0]        vram_rdata,
    output logic               err_range,
    output logic               err_ovf
);

    localparam int          EW      = entry_width(VRAM_AW);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int          SW      = $clog2(STARVE_LIM + 1);
    localparam logic [32:0] WIN_END = {1'b0, ADDR_BASE} + (33'd4 << VRAM_AW);

    logic               in_range_s;
    logic [VRAM_AW-1:0] word_s;
    logic               push_s;
    logic               pop_s;
    logic               ovf_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;
    logic [CW-1:0]      count_nxt_s;
    logic [EW-1:0]      head_s;
    logic               starve_hit_s;
    grant_e             grant_s;
    grant_e             grant_r;
    logic [SW-1:0]      starve_cnt_r;
    logic               core_busy_r;
    logic               err_range_r;
    logic               err_ovf_r;
    logic [31:0]        scan_data_r;

    // Window decode; the 33-bit bound keeps windows near the top of the map exact
    always_comb begin
        in_range_s  = (video_addr >= ADDR_BASE) && ({1'b0, video_addr} < WIN_END);
        word_s      = VRAM_AW'((video_addr - ADDR_BASE) >> 2);
        push_s      = video_we && in_range_s && (!fifo_full_s || pop_s);
        ovf_s       = video_we && in_range_s && fifo_full_s && !pop_s;
        count_nxt_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
    end

    vram_wr_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({word_s, video_data}),
        .pop       (pop_s),
        .head_data (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Per-cycle grant; nothing touches the RAM while reset is asserted
    always_comb begin
        starve_hit_s = !fifo_empty_s && (starve_cnt_r == SW'(STARVE_LIM));
        if (rst) begin
            grant_s = G_IDLE;
        end else if (scan_req && !starve_hit_s) begin
            grant_s = G_SCAN;
        end else if (!fifo_empty_s) begin
            grant_s = starve_hit_s ? G_FORCE_WR : G_WRITE;
        end else begin
            grant_s = G_IDLE;
        end
    end

    // RAM port drive follows the grant
    always_comb begin
        scan_gnt   = (grant_s == G_SCAN);
        pop_s      = (grant_s == G_WRITE) || (grant_s == G_FORCE_WR);
        vram_en    = (grant_s != G_IDLE);
        vram_we    = pop_s;
        vram_addr  = scan_gnt ? scan_addr : head_s[EW-1:32];
        vram_wdata = pop_s ? head_s[31:0] : 32'd0;
    end

    // Grant history, starvation guard, stall and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r      <= G_IDLE;
            starve_cnt_r <= '0;
            core_busy_r  <= 1'b0;
            err_range_r  <= 1'b0;
            err_ovf_r    <= 1'b0;
            scan_data_r  <= 32'd0;
        end else begin
            grant_r <= grant_s;
            if ((grant_s == G_SCAN) && !fifo_empty_s) begin
                if (starve_cnt_r != SW'(STARVE_LIM)) begin
                    starve_cnt_r <= starve_cnt_r + SW'(1);
                end
            end else begin
                starve_cnt_r <= '0;
            end
            core_busy_r <= (count_nxt_s >= CW'(FIFO_DEPTH - 1));
            if (video_we && !in_range_s) begin
                err_range_r <= 1'b1;
            end
            if (ovf_s) begin
                err_ovf_r <= 1'b1;
            end
            if (grant_r == G_SCAN) begin
                scan_data_r <= vram_rdata;
            end
        end
    end

    // Read data is presented straight from the RAM in the return cycle, then held
    assign scan_valid = (grant_r == G_SCAN);
    assign scan_data  = scan_valid ? vram_rdata : scan_data_r;
    assign core_busy  = core_busy_r;
    assign err_range  = err_range_r;
    assign err_ovf    = err_ovf_r;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomised scoreboard bench for vram_port_arbiter against a queue-based
// reference model of the arbitration rules and a behavioural RAM.
module tb_vram_port_arbiter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          video_we;
    logic [31:0]   video_addr;
    logic [31:0]   video_data;
    logic          core_busy;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_gnt;
    logic          scan_valid;
    logic [31:0]   scan_data;
    logic          vram_en;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [31:0]   vram_wdata;
    logic [31:0]   vram_rdata;
    logic          err_range;
    logic          err_ovf;

    vram_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .video_we   (video_we),
        .video_addr (video_addr),
        .video_data (video_data),
        .core_busy  (core_busy),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_gnt   (scan_gnt),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .vram_en    (vram_en),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .err_range  (err_range),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]      env_ram [0:32767];
    logic [31:0]      mdl_ram [0:32767];
    logic [AW+31:0]   exp_wr[$];
    logic [31:0]      exp_rd[$];
    logic [AW+31:0]   pend[$];
    int               m_starve = 0;
    bit               m_busy = 1'b0;
    bit               m_err_range = 1'b0;
    bit               m_err_ovf = 1'b0;
    bit               m_prev_scan = 1'b0;
    bit               last_scan_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM with one cycle of read latency
    always @(posedge clk) begin
        if (vram_en === 1'b1) begin
            if (vram_we === 1'b1) env_ram[vram_addr] <= vram_wdata;
            else                  vram_rdata <= env_ram[vram_addr];
        end
    end

    // Scoreboard monitor: every RAM write and every read return consumes one expectation
    always @(negedge clk) begin
        if (vram_en === 1'b1 && vram_we === 1'b1) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, none queued", vram_addr, vram_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_wr.pop_front();
                if ({vram_addr, vram_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write_entry: got %0h/%0h expected %0h/%0h",
                             vram_addr, vram_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
        if (scan_valid === 1'b1) begin
            n_checks++;
            if (exp_rd.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got data %0h, none pending", scan_data);
            end else begin
                logic [31:0] d;
                d = exp_rd.pop_front();
                if (scan_data !== d) begin
                    n_fail++;
                    $display("FAIL read_data: got %0h expected %0h", scan_data, d);
                end
            end
        end
    end

    // One clock of stimulus plus reference-model bookkeeping; entered just after a rising edge
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input bit sreq, input logic [AW-1:0] sa, input bit r);
        int  g;            // 0 idle, 1 scan, 2 write
        bit  hit;
        bit  in_rng;
        bit  accept;
        int  size_before;
        logic [AW-1:0] w;
        rst = r; video_we = we; video_addr = a; video_data = d; scan_req = sreq; scan_addr = sa;
        size_before = pend.size();
        hit    = (size_before != 0) && (m_starve == 8);
        in_rng = (a >= 32'h0000_8000) && (a < 32'h0002_8000);
        w      = AW'((a - 32'h0000_8000) >> 2);
        if (r)                      g = 0;
        else if (sreq && !hit)      g = 1;
        else if (size_before != 0)  g = 2;
        else                        g = 0;
        accept = !r && we && in_rng && (size_before < 4 || g == 2);
        if (g == 1) exp_rd.push_back(mdl_ram[sa]);
        if (accept) exp_wr.push_back({w, d});
        last_scan_pending = sreq && (g != 1);
        @(negedge clk);
        check("scan_gnt", scan_gnt, 64'(g == 1));
        check("vram_we", 64'(vram_en && vram_we), 64'(g == 2));
        if (g == 1) check("scan_addr_fwd", {vram_en, vram_we, vram_addr}, {2'b10, sa});
        check("scan_valid", scan_valid, 64'(m_prev_scan));
        check("core_busy", core_busy, 64'(m_busy));
        check("err_range", err_range, 64'(m_err_range));
        check("err_ovf", err_ovf, 64'(m_err_ovf));
        @(posedge clk);
        if (r) begin
            pend.delete(); exp_wr.delete(); exp_rd.delete();
            m_starve = 0; m_busy = 0; m_err_range = 0; m_err_ovf = 0; m_prev_scan = 0;
        end else begin
            if (g == 2) begin
                mdl_ram[pend[0][AW+31:32]] = pend[0][31:0];
                void'(pend.pop_front());
            end
            if (g == 1 && size_before != 0) m_starve = (m_starve < 8) ? m_starve + 1 : 8;
            else                            m_starve = 0;
            if (accept) pend.push_back({w, d});
            if (we && !in_rng) m_err_range = 1'b1;
            if (we && in_rng && !accept) m_err_ovf = 1'b1;
            m_busy      = (pend.size() >= 3);
            m_prev_scan = (g == 1);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            env_ram[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            mdl_ram[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        end
        env_ram[16] = 32'h1234_5678;
        mdl_ram[16] = 32'h1234_5678;
        rst = 1'b1; video_we = 1'b0; video_addr = 32'd0; video_data = 32'd0;
        scan_req = 1'b0; scan_addr = '0; vram_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_scan_data", scan_data, 64'd0);
        check("reset_core_busy", core_busy, 64'd0);
        @(posedge clk);
        #1;

        // Single store with no scanout traffic
        step(1'b1, 32'h0000_8004, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
        idle(3);
        // Read of a preloaded word
        step(1'b0, 32'd0, 32'd0, 1'b1, 15'h10, 1'b0);
        idle(2);
        // Starvation guard: three stores under continuous scanout
        for (int k = 0; k < 3; k++) step(1'b1, 32'h0000_8000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b1, AW'(k), 1'b0);
        for (int k = 0; k < 30; k++) step(1'b0, 32'd0, 32'd0, 1'b1, AW'(k + 3), 1'b0);
        // Overflow: five back-to-back stores while scanout holds the port
        for (int k = 0; k < 5; k++) step(1'b1, 32'h0000_8100 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1'b1, AW'(k), 1'b0);
        for (int k = 0; k < 40; k++) step(1'b0, 32'd0, 32'd0, 1'b1, AW'(k), 1'b0);
        // Window boundaries
        step(1'b1, 32'h0000_7FFC, 32'h1111_1111, 1'b0, '0, 1'b0);
        step(1'b1, 32'h0002_8000, 32'h2222_2222, 1'b0, '0, 1'b0);
        step(1'b1, 32'h0002_7FFC, 32'h3333_3333, 1'b0, '0, 1'b0);
        idle(3);
        // Reset with queued writes and a read in flight
        step(1'b1, 32'h0000_8200, 32'hC000_0001, 1'b1, 15'h5, 1'b0);
        step(1'b1, 32'h0000_8204, 32'hC000_0002, 1'b1, 15'h6, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 15'h7, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 15'h7, 1'b1);
        idle(4);

        // Randomised traffic; scanout holds its request until granted
        begin
            bit            sreq;
            logic [AW-1:0] sa;
            logic [31:0]   a;
            sreq = 1'b0; sa = '0;
            for (int c = 0; c < 3000; c++) begin
                if (!last_scan_pending) begin
                    sreq = ($urandom_range(0, 99) < 70);
                    sa   = AW'($urandom_range(0, 31));
                end
                case ($urandom_range(0, 9))
                    0:       a = 32'h0000_7FFC;
                    1:       a = 32'h0002_8000 + 32'($urandom_range(0, 3));
                    default: a = 32'h0000_8000 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
                endcase
                step(($urandom_range(0, 99) < 45), a, $urandom, sreq, sa, ($urandom_range(0, 499) == 0));
            end
        end
        idle(20);
        check("writes_drained", 64'(exp_wr.size()), 64'd0);
        check("reads_drained", 64'(exp_rd.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
